vend_money_ledger: RTL
======================

Name: vend_money_ledger

Overview:
- Transaction and money-accounting core of the vending machine.
- Consumes the one-cycle debounced pulses from the key filters (coins, goods/confirm/change/cancel keys, goods code and quantity switches).
- Produces the registered need_money / input_money / change_money values that drive the seven-segment display stage.
- Runs a selection → payment → settlement state machine with priced goods, coin accumulation, overflow rejection, refund, and a timed result hold.

Parameters:
- MAX_MONEY, 255: ceiling for input_money; a coin that would exceed it is rejected.
- HOLD_CYCLES, 300000000: cycles the settlement result is held in DONE before auto-clear (3 s at 100 MHz); 32-bit counter.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- in_money_one  in  1  1-yuan coin pulse.
- in_money_five  in  1  5-yuan coin pulse.
- in_money_ten  in  1  10-yuan coin pulse.
- in_money_twenty  in  1  20-yuan coin pulse.
- in_money_fifty  in  1  50-yuan coin pulse.
- sys_Goods  in  1  goods-select pulse; latches code and quantity.
- sys_Confirm  in  1  confirm-selection pulse.
- sys_Change  in  1  settle/change-request pulse.
- sys_Cancel  in  1  cancel/refund pulse.
- type_SW_high  in  3  goods code tens digit (0-7).
- type_SW_low  in  3  goods code units digit (0-7).
- num_SW  in  2  quantity (0-3).
- need_money  out  8  price due, binary yuan.
- input_money  out  8  coins inserted, binary yuan.
- change_money  out  8  change or refund, binary yuan.
- dispense  out  1  one-cycle pulse on successful purchase.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- state_o  out  2  current state: IDLE=0, SELECT=1, PAY=2, DONE=3.

Behaviour:
- Reset: async, active-high. state=IDLE; all money outputs 0; dispense=0; coin_reject=0; hold counter=0. Reset mid-transaction discards all money with no pulse.
- Timing: all outputs registered; each reacts on the clock edge after the input pulse (1-cycle latency).
- Price: price = (10*type_SW_high + type_SW_low) * num_SW, computed in 8 bits. Max is 77*3 = 231, so no overflow.
- num_SW = 0: the sys_Goods pulse is ignored in every state.
- Coin sum: all coin pulses high in the same cycle are summed (max 86).
- Coin acceptance: the sum is added only if input_money + sum <= MAX_MONEY. Otherwise the whole sum is rejected: coin_reject pulses and input_money is unchanged.
- Event priority per cycle: sys_Cancel > sys_Change > sys_Confirm > sys_Goods > coins. Lower-priority events in the same cycle are dropped, except coins in PAY when the only other event is sys_Confirm or sys_Goods (both no-ops in PAY).
- IDLE:
  - need/input/change = 0.
  - sys_Goods (num≠0): need_money=price, go to SELECT.
  - Coins: coin_reject pulses, nothing is stored.
- SELECT:
  - sys_Goods re-latches need_money.
  - sys_Confirm: go to PAY.
  - sys_Cancel: clear need_money, go to IDLE.
  - Coins: rejected (coin_reject pulses).
- PAY:
  - Coins accumulate per the acceptance rule.
  - sys_Change with input_money >= need_money: change_money = input_money - need_money, dispense pulses, go to DONE.
  - sys_Change with input_money < need_money: ignored, no state change.
  - sys_Cancel: change_money = input_money (refund), need_money = 0, no dispense, go to DONE.
- DONE:
  - need/input/change are held; the hold counter counts up.
  - When the counter reaches HOLD_CYCLES-1: clear all money outputs, go to IDLE.
  - sys_Goods (num≠0) before timeout: clear input/change, load need_money=price, reset the counter, go to SELECT.
  - sys_Cancel: clear all, go to IDLE.
  - Coins: rejected.
- dispense and coin_reject are never high for more than one consecutive cycle per triggering event.

Optional Feature:
- Macro: VEND_AUTO_SETTLE_EN.
- Defined: in PAY, whenever the registered input_money >= need_money at the end of a cycle (including after a coin lands), the block settles on the next cycle exactly as sys_Change would: compute change, pulse dispense, go to DONE. sys_Change stays functional.
- Undefined: settlement happens only on sys_Change, as described above.

Test Plan:
- Reset, sys_Goods with high=1, low=2, num=2 → next cycle need_money=24, state=SELECT. sys_Confirm → PAY. Coins 20 then 5 → input_money=25. sys_Change → change_money=1, one dispense pulse, state=DONE.
- In PAY with need=24: coin 10, then sys_Change → no change in state or outputs. sys_Cancel → change_money=10, need_money=0, no dispense, DONE.
- MAX_MONEY=60, PAY: coins 50 then 20 → second coin rejected (coin_reject=1 for one cycle), input_money stays 50. Same-cycle coins 5+1 → input_money=56.
- HOLD_CYCLES=10: after settlement, count 10 cycles → all money outputs 0, state=IDLE. Repeat, with sys_Goods (high=0, low=3, num=1) at cycle 4 → need_money=3, input=0, change=0, state=SELECT.
- Assert sys_rst asynchronously (between clock edges) in PAY with input_money=30 → outputs 0 and state IDLE immediately, before the next clock edge. Coin pulse in IDLE → coin_reject pulses, input_money stays 0.
- With VEND_AUTO_SETTLE_EN defined: need=24, coins 20 then 5 → without sys_Change, one cycle after input_money=25: dispense pulses, change_money=1.

Source files
------------

// File: rtl/vend_money_ledger_if.sv
// Signal bundle between the key-filter stage and the money ledger.
// master: key filters / display side (drives pulses and switches, reads money values)
// slave : vend_money_ledger (reads pulses and switches, drives money values and strobes)
interface vend_money_ledger_if;
  logic       in_money_one;
  logic       in_money_five;
  logic       in_money_ten;
  logic       in_money_twenty;
  logic       in_money_fifty;
  logic       sys_Goods;
  logic       sys_Confirm;
  logic       sys_Change;
  logic       sys_Cancel;
  logic [2:0] type_SW_high;
  logic [2:0] type_SW_low;
  logic [1:0] num_SW;
  logic [7:0] need_money;
  logic [7:0] input_money;
  logic [7:0] change_money;
  logic       dispense;
  logic       coin_reject;
  logic [1:0] state_o;

  modport master (
    output in_money_one, in_money_five, in_money_ten, in_money_twenty, in_money_fifty,
    output sys_Goods, sys_Confirm, sys_Change, sys_Cancel,
    output type_SW_high, type_SW_low, num_SW,
    input  need_money, input_money, change_money, dispense, coin_reject, state_o
  );

  modport slave (
    input  in_money_one, in_money_five, in_money_ten, in_money_twenty, in_money_fifty,
    input  sys_Goods, sys_Confirm, sys_Change, sys_Cancel,
    input  type_SW_high, type_SW_low, num_SW,
    output need_money, input_money, change_money, dispense, coin_reject, state_o
  );
endinterface

// File: rtl/vend_money_ledger.sv
// Vending machine transaction / money-accounting core.
// Runs selection -> payment -> settlement, accumulates coins with an overflow
// ceiling, computes change or refund and holds the result for a timed period.
// Ports:
//   sys_clk  : system clock, rising edge
//   sys_rst  : asynchronous active-high reset
//   bus      : vend_money_ledger_if.slave (coin/key pulses, goods switches in;
//              need/input/change money, dispense, coin_reject, state_o out)
// Optional feature macro VEND_AUTO_SETTLE_EN: when defined, PAY settles on its
// own as soon as the inserted money covers the price.
module vend_money_ledger #(
  parameter int MAX_MONEY   = 255,
  parameter int HOLD_CYCLES = 300000000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  vend_money_ledger_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    PAY    = 2'd2,
    DONE   = 2'd3
  } state_t;

`ifdef VEND_AUTO_SETTLE_EN
  localparam bit AUTO_SETTLE = 1'b1;
`else
  localparam bit AUTO_SETTLE = 1'b0;
`endif

  state_t      state, state_n;
  logic [7:0]  need_q, need_n;
  logic [7:0]  input_q, input_n;
  logic [7:0]  change_q, change_n;
  logic        dispense_q, dispense_n;
  logic        reject_q, reject_n;
  logic [31:0] hold_cnt, hold_n;

  logic [7:0]  code, price, coin_sum;
  logic [8:0]  money_sum;
  logic        coin_any, coin_ok, goods_ev, hold_last, covered, settle_ev;

  always_comb begin
    code      = 8'(bus.type_SW_high) * 8'd10 + 8'(bus.type_SW_low);
    price     = code * 8'(bus.num_SW);
    coin_sum  = (bus.in_money_one    ? 8'd1  : 8'd0) +
                (bus.in_money_five   ? 8'd5  : 8'd0) +
                (bus.in_money_ten    ? 8'd10 : 8'd0) +
                (bus.in_money_twenty ? 8'd20 : 8'd0) +
                (bus.in_money_fifty  ? 8'd50 : 8'd0);
    coin_any  = bus.in_money_one | bus.in_money_five | bus.in_money_ten |
                bus.in_money_twenty | bus.in_money_fifty;
    // 9-bit sum so the ceiling compare sees a carry out of 8 bits
    money_sum = {1'b0, input_q} + {1'b0, coin_sum};
    coin_ok   = money_sum <= 9'(MAX_MONEY);
    // A quantity of zero makes the goods key a no-op everywhere
    goods_ev  = bus.sys_Goods && (bus.num_SW != 2'd0);
    hold_last = hold_cnt == 32'(HOLD_CYCLES - 1);
    covered   = input_q >= need_q;
    settle_ev = bus.sys_Change | (AUTO_SETTLE & covered);
  end

  always_comb begin
    state_n    = state;
    need_n     = need_q;
    input_n    = input_q;
    change_n   = change_q;
    dispense_n = 1'b0;
    reject_n   = 1'b0;
    hold_n     = hold_cnt;
    unique case (state)
      IDLE: begin
        // Cancel/Change/Confirm are no-ops here but still outrank goods and coins
        if (!(bus.sys_Cancel | bus.sys_Change | bus.sys_Confirm)) begin
          if (goods_ev) begin
            need_n  = price;
            state_n = SELECT;
          end else if (coin_any) begin
            reject_n = 1'b1;
          end
        end
      end
      SELECT: begin
        if (bus.sys_Cancel) begin
          need_n  = 8'd0;
          state_n = IDLE;
        end else if (bus.sys_Change) begin
          // dropped
        end else if (bus.sys_Confirm) begin
          state_n = PAY;
        end else if (goods_ev) begin
          need_n = price;
        end else if (coin_any) begin
          reject_n = 1'b1;
        end
      end
      PAY: begin
        if (bus.sys_Cancel) begin
          change_n = input_q;
          need_n   = 8'd0;
          hold_n   = 32'd0;
          state_n  = DONE;
        end else if (settle_ev) begin
          // An uncovered change request is swallowed, coins included
          if (covered) begin
            change_n   = input_q - need_q;
            dispense_n = 1'b1;
            hold_n     = 32'd0;
            state_n    = DONE;
          end
        end else if (coin_any) begin
          // Confirm/Goods are no-ops in PAY, so coins still land alongside them
          if (coin_ok) input_n  = money_sum[7:0];
          else         reject_n = 1'b1;
        end
      end
      DONE: begin
        if (bus.sys_Cancel) begin
          need_n   = 8'd0;
          input_n  = 8'd0;
          change_n = 8'd0;
          hold_n   = 32'd0;
          state_n  = IDLE;
        end else if (goods_ev && !(bus.sys_Change | bus.sys_Confirm)) begin
          need_n   = price;
          input_n  = 8'd0;
          change_n = 8'd0;
          hold_n   = 32'd0;
          state_n  = SELECT;
        end else if (hold_last) begin
          need_n   = 8'd0;
          input_n  = 8'd0;
          change_n = 8'd0;
          hold_n   = 32'd0;
          state_n  = IDLE;
        end else begin
          hold_n = hold_cnt + 32'd1;
          if (coin_any && !(bus.sys_Change | bus.sys_Confirm | bus.sys_Goods))
            reject_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      need_q     <= 8'd0;
      input_q    <= 8'd0;
      change_q   <= 8'd0;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      hold_cnt   <= 32'd0;
    end else begin
      state      <= state_n;
      need_q     <= need_n;
      input_q    <= input_n;
      change_q   <= change_n;
      dispense_q <= dispense_n;
      reject_q   <= reject_n;
      hold_cnt   <= hold_n;
    end
  end

  assign bus.need_money   = need_q;
  assign bus.input_money  = input_q;
  assign bus.change_money = change_q;
  assign bus.dispense     = dispense_q;
  assign bus.coin_reject  = reject_q;
  assign bus.state_o      = state;

endmodule
